dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipelined RISC-V core's M stage (primary) and a debug/loader requester (secondary, valid/ready).
- The CPU has priority. Debug traffic uses idle memory cycles.
- A starvation counter, or an explicit halt request, forces a debug slot by asserting cpu_stall.
- Sits between the core's Address/WriteData/MemWrite/ReadData pins and the data RAM. The RAM read is combinational (same-cycle).

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core M stage, the debug/loader requester and the data RAM.
// master = requesters + RAM model side, slave = the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req_valid;
    logic              dbg_req_ready;
    logic              dbg_req_we;
    logic [ADDR_W-1:0] dbg_req_addr;
    logic [DATA_W-1:0] dbg_req_wdata;
    logic              dbg_halt;
    logic              dbg_rsp_valid;
    logic [DATA_W-1:0] dbg_rsp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_halt,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_halt,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU M stage has priority, debug uses idle cycles,
// starvation or dbg_halt force debug slots. Optional stats via DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    dmem_arbiter_if.slave bus,
    output logic [8:0] stat_dbg_grants,
    output logic [8:0] stat_stalls
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FORCE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              cpu_act_c;
    logic              stall_c;
    logic              grant_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              mem_we_c;

    // Grant and memory-port mux; the CPU never writes while stalled.
    always_comb begin
        cpu_act_c   = bus.cpu_re | bus.cpu_we;
        stall_c     = (state != RUN);
        grant_c     = bus.dbg_req_valid & (stall_c | ~cpu_act_c);
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
        mem_we_c    = bus.cpu_we & ~stall_c;
        if (grant_c) begin
            mem_addr_c  = bus.dbg_req_addr;
            mem_wdata_c = bus.dbg_req_wdata;
            mem_we_c    = bus.dbg_req_we;
        end
    end

    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_wdata     = mem_wdata_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.cpu_rdata     = bus.mem_rdata;
    assign bus.cpu_stall     = stall_c;
    assign bus.dbg_req_ready = grant_c;
    assign bus.dbg_rsp_valid = rsp_valid_q;
    assign bus.dbg_rsp_data  = rsp_data_q;

    // State, starvation counter and the one-cycle debug response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            starve_cnt  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= grant_c;
            if (grant_c) begin
                rsp_data_q <= bus.dbg_req_we ? '0 : bus.mem_rdata;
            end
            if (bus.dbg_halt) begin
                state      <= HALTED;
                starve_cnt <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.dbg_req_valid && cpu_act_c) begin
                            if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                                state      <= FORCE;
                                starve_cnt <= '0;
                            end else begin
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= RUN;
                        starve_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Wrapping event counters for debug transfers and stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_dbg_grants <= '0;
            stat_stalls     <= '0;
        end else begin
            if (grant_c) stat_dbg_grants <= stat_dbg_grants + 9'd1;
            if (stall_c) stat_stalls     <= stat_stalls + 9'd1;
        end
    end
`else
    assign stat_dbg_grants = '0;
    assign stat_stalls     = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter against a cycle-level behavioural model.
module tb_dmem_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [8:0] stat_dbg_grants;
    logic [8:0] stat_stalls;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .stat_dbg_grants(stat_dbg_grants), .stat_stalls(stat_stalls)
    );

    // RAM seen by the DUT: combinational read, clocked write
    logic [DW-1:0] ram [DEPTH];
    assign bus.mem_rdata = ram[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_halt, m_force, m_rsp_v;
    int            m_streak, m_grants, m_stalls;
    logic [DW-1:0] m_rsp_d;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_force = 0; m_rsp_v = 0; m_rsp_d = '0;
        m_streak = 0; m_grants = 0; m_stalls = 0;
    endtask

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 7)) << 2;
    endfunction

    // One clock cycle: drive, check combinational outputs and response, advance the model
    task automatic cycle(input bit re, input bit we, input logic [31:0] ca, input logic [31:0] cwd,
                         input bit dv, input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input bit halt);
        bit exp_stall, exp_ready, exp_we;
        logic [31:0] exp_addr, exp_wd;
        @(negedge clk);
        bus.cpu_re = re; bus.cpu_we = we; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
        bus.dbg_req_valid = dv; bus.dbg_req_we = dwe; bus.dbg_req_addr = da;
        bus.dbg_req_wdata = dwd; bus.dbg_halt = halt;
        #1;
        exp_stall = m_halt | m_force;
        exp_ready = dv & (exp_stall | !(re | we));
        exp_we    = exp_ready ? dwe : (we & !exp_stall);
        exp_addr  = exp_ready ? da : ca;
        exp_wd    = exp_ready ? dwd : cwd;
        check("cpu_stall", 32'(bus.cpu_stall), 32'(exp_stall));
        check("dbg_req_ready", 32'(bus.dbg_req_ready), 32'(exp_ready));
        check("mem_we", 32'(bus.mem_we), 32'(exp_we));
        check("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wd);
        check("cpu_rdata", bus.cpu_rdata, ref_mem[exp_addr[7:2]]);
        check("dbg_rsp_valid", 32'(bus.dbg_rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v) check("dbg_rsp_data", bus.dbg_rsp_data, m_rsp_d);

        m_rsp_v = exp_ready;
        if (exp_ready) m_rsp_d = dwe ? 32'h0 : ref_mem[da[7:2]];
        if (exp_we) ref_mem[exp_addr[7:2]] = exp_wd;
        if (exp_ready) m_grants++;
        if (exp_stall) m_stalls++;
        if (halt) begin
            m_halt = 1; m_force = 0; m_streak = 0;
        end else if (m_halt || m_force) begin
            m_halt = 0; m_force = 0; m_streak = 0;
        end else if (dv && (re || we)) begin
            m_streak++;
            if (m_streak == int'(LIMIT)) begin
                m_force = 1; m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic check_stats(input string tag, input int g, input int s);
`ifdef DMEM_ARB_STATS_EN
        check({tag, "_grants"}, 32'(stat_dbg_grants), 32'(g % 512));
        check({tag, "_stalls"}, 32'(stat_stalls), 32'(s % 512));
`else
        check({tag, "_grants"}, 32'(stat_dbg_grants), 32'(g * 0));
        check({tag, "_stalls"}, 32'(stat_stalls), 32'(s * 0));
`endif
    endtask

    initial begin
        bit hold_halt;
        reset = 1'b1;
        bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req_valid = 0; bus.dbg_req_we = 0; bus.dbg_req_addr = '0;
        bus.dbg_req_wdata = '0; bus.dbg_halt = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = 32'(i) * 32'h0101_0101;
            ref_mem[i] = ram[i];
        end
        model_reset();
        #12;
        check("reset_stall", 32'(bus.cpu_stall), 32'h0);
        check("reset_rsp_valid", 32'(bus.dbg_rsp_valid), 32'h0);
        check("reset_rsp_data", bus.dbg_rsp_data, 32'h0);
        check_stats("reset", 0, 0);
        @(negedge clk) reset = 1'b0;

        // Idle CPU: debug write then read-back
        cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 0);
        idle();
        check("t1_readback", bus.dbg_rsp_data, 32'hDEADBEEF);

        // Starvation: CPU loads every cycle with debug pending
        for (int i = 0; i < 12; i++) cycle(1, 0, 32'h8, 32'h0, 1, 0, 32'h40, 32'h0, 0);
        idle();

        // Halt for 6 cycles while the CPU stores
        for (int i = 0; i < 6; i++)
            cycle(0, 1, raddr(), $urandom, 1, 1, raddr(), $urandom, 1);
        for (int i = 0; i < 3; i++)
            cycle(0, 1, raddr(), $urandom, 0, 0, 32'h0, 32'h0, 0);

        // Same-address collision: CPU store lands first, debug write later
        cycle(0, 1, 32'h10, 32'h1111_1111, 1, 1, 32'h10, 32'h2222_2222, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'h2222_2222, 0);
        idle();
        check("t4_final_mem", ram[4], 32'h2222_2222);

        // Async reset while in FORCE with a debug read being accepted
        for (int i = 0; i < int'(LIMIT); i++) cycle(1, 0, 32'h8, 32'h0, 1, 0, 32'h40, 32'h0, 0);
        @(negedge clk);
        bus.dbg_req_we = 0; bus.dbg_req_addr = 32'h40; bus.dbg_req_valid = 1;
        #1;
        check("t5_force_stall", 32'(bus.cpu_stall), 32'h1);
        check("t5_force_ready", 32'(bus.dbg_req_ready), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5_reset_stall", 32'(bus.cpu_stall), 32'h0);
        check("t5_reset_rsp", 32'(bus.dbg_rsp_valid), 32'h0);
        @(negedge clk);
        bus.cpu_re = 0; bus.dbg_req_valid = 0;
        reset = 1'b0;
        model_reset();

        // Stats: two forced slots without debug traffic, then three transfers
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(LIMIT); i++) cycle(1, 0, 32'h8, 32'h0, 1, 0, 32'h40, 32'h0, 0);
            cycle(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 1, 1, raddr(), $urandom, 0);
        idle();
        check_stats("t6", 3, 2);

        // Randomised traffic
        hold_halt = 0;
        for (int i = 0; i < 600; i++) begin
            bit act, ld;
            if (!hold_halt && $urandom_range(0, 40) == 0) hold_halt = 1;
            else if (hold_halt && $urandom_range(0, 4) == 0) hold_halt = 0;
            act = ($urandom_range(0, 9) < 7);
            ld  = $urandom_range(0, 1) == 1;
            cycle(act & ld, act & !ld, raddr(), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, raddr(), $urandom,
                  hold_halt);
        end
        idle();
        check_stats("random", m_grants, m_stalls);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
